// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared types and constants for the writeback/register-file stage
package wb_regfile_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_REG_ADDR_W = 3;

  // Writeback source select
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2,
    WB_NPC = 2'd3
  } wb_sel_e;

  // Condition-code bit positions within psr {N,Z,P}
  localparam int PSR_N = 2;
  localparam int PSR_Z = 1;
  localparam int PSR_P = 0;

  localparam logic [2:0] PSR_RESET = 3'b010;

  // One-hot condition code from the sign bit and a zero flag
  function automatic logic [2:0] psr_code(input logic neg, input logic zero);
    logic [2:0] code;
    code = '0;
    if (zero) begin
      code[PSR_Z] = 1'b1;
    end else if (neg) begin
      code[PSR_N] = 1'b1;
    end else begin
      code[PSR_P] = 1'b1;
    end
    return code;
  endfunction

endpackage

// File: rtl/wb_regfile_array.sv
// rtl/wb_regfile_array.sv - NUM_REGS x DATA_W storage, one write port, two combinational read ports
// Ports:
//   clk_i, rst_n_i         clock, asynchronous active-low reset (clears all entries)
//   we_i, waddr_i, wdata_i write port, committed on rising clk_i
//   raddr1_i/rdata1_o      read port 1 (combinational, pre-write contents)
//   raddr2_i/rdata2_o      read port 2 (combinational, pre-write contents)
module wb_regfile_array
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_REG_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] rf_q [NUM_REGS];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (we_i) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = rf_q[raddr1_i];
  assign rdata2_o = rf_q[raddr2_i];

endmodule

// File: rtl/wb_regfile_stage.sv
// rtl/wb_regfile_stage.sv - writeback source mux, register file with forwarding, condition codes
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   enable_writeback        commits wb_data to rf[dr] and updates psr this cycle
//   W_control               source select (ALU, memory, PC, next PC)
//   aluout_in, memout, pcout_in, npc   candidate write data
//   dr, sr1, sr2            destination and two source register indices
//   VSR1, VSR2              registered read data (1-cycle latency)
//   psr                     registered one-hot {N,Z,P}
//   wb_data                 combinational selected write data
//   wb_valid                high the cycle after a committed write
module wb_regfile_stage
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int BYPASS     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable_writeback,
  input  logic [1:0]            W_control,
  input  logic [DATA_W-1:0]     aluout_in,
  input  logic [DATA_W-1:0]     memout,
  input  logic [DATA_W-1:0]     pcout_in,
  input  logic [DATA_W-1:0]     npc,
  input  logic [REG_ADDR_W-1:0] dr,
  input  logic [REG_ADDR_W-1:0] sr1,
  input  logic [REG_ADDR_W-1:0] sr2,
  output logic [DATA_W-1:0]     VSR1,
  output logic [DATA_W-1:0]     VSR2,
  output logic [2:0]            psr,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  wb_valid
);

  logic [DATA_W-1:0] rf_rd1, rf_rd2;
  logic [DATA_W-1:0] vsr1_d, vsr1_q;
  logic [DATA_W-1:0] vsr2_d, vsr2_q;
  logic [2:0]        psr_d, psr_q;
  logic              wb_valid_q;

  // Unknown selects fall to the ALU source; harmless because nothing
  // consumes wb_data unless enable_writeback is high.
  always_comb begin
    wb_data = aluout_in;
    case (wb_sel_e'(W_control))
      WB_ALU:  wb_data = aluout_in;
      WB_MEM:  wb_data = memout;
      WB_PC:   wb_data = pcout_in;
      WB_NPC:  wb_data = npc;
      default: wb_data = aluout_in;
    endcase
  end

  wb_regfile_array #(
    .DATA_W (DATA_W),
    .ADDR_W (REG_ADDR_W)
  ) u_array (
    .clk_i    (clock),
    .rst_n_i  (reset),
    .we_i     (enable_writeback),
    .waddr_i  (dr),
    .wdata_i  (wb_data),
    .raddr1_i (sr1),
    .raddr2_i (sr2),
    .rdata1_o (rf_rd1),
    .rdata2_o (rf_rd2)
  );

  // Forwarding: a read that collides with this cycle's write sees the new
  // value immediately when BYPASS is set, otherwise the array's old value.
  always_comb begin
    vsr1_d = rf_rd1;
    vsr2_d = rf_rd2;
    if ((BYPASS != 0) && enable_writeback) begin
      if (sr1 == dr) vsr1_d = wb_data;
      if (sr2 == dr) vsr2_d = wb_data;
    end
  end

  always_comb begin
    psr_d = psr_q;
    if (enable_writeback) begin
      psr_d = psr_code(wb_data[DATA_W-1], (wb_data == '0));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vsr1_q     <= '0;
      vsr2_q     <= '0;
      psr_q      <= PSR_RESET;
      wb_valid_q <= 1'b0;
    end else begin
      vsr1_q     <= vsr1_d;
      vsr2_q     <= vsr2_d;
      psr_q      <= psr_d;
      wb_valid_q <= enable_writeback;
    end
  end

  assign VSR1     = vsr1_q;
  assign VSR2     = vsr2_q;
  assign psr      = psr_q;
  assign wb_valid = wb_valid_q;

endmodule
